// File: rtl/cfg_chain_loader_if.sv
// cfg_chain_loader_if: host bitstream word handshake for the config chain loader.
//   cfg_data  - one bitstream word, bit 0 goes onto the chain first
//   cfg_valid - host has a word on cfg_data
//   cfg_ready - loader takes the word at the next edge if cfg_valid is high
// master = host side, slave = loader side.
interface cfg_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: fills the CLB/SB/CB configuration scan chain from a word stream.
//   prog_clk, prog_rst  - clock and synchronous active-high reset
//   start, abort        - begin a load (from IDLE) / cancel an active load
//   cfg                 - host word handshake (slave side)
//   prog_in, prog_en    - serial data and shift enable into the chain head
//   prog_out            - chain tail, brought in only as a readback tap
//   fabric_en           - clb_clk gate enable, high once the chain is fully loaded
//   busy, done, aborted - status: active / end-of-load pulse / last load cancelled
//   bit_count           - bits shifted in the current or last load
// Each accepted word is shifted out LSB-first; the load ends after exactly
// CHAIN_LEN bits, discarding whatever is left of the final word.
module cfg_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_rst,
  input  logic              start,
  input  logic              abort,
  cfg_chain_loader_if.slave cfg,
  output logic              prog_in,
  output logic              prog_en,
  input  logic              prog_out,
  output logic              fabric_en,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  bit_count
);
  localparam int               BL_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] sh_buf;
  logic [BL_W-1:0]   bits_left;
  logic              accept;
  logic              unused_tap;

  // Tail of the chain is routed here for debug probing only.
  assign unused_tap = prog_out;

  always_ff @(posedge prog_clk) begin
    if (prog_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cfg.cfg_ready = 1'b0;
    prog_en       = 1'b0;
    prog_in       = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    accept        = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && !abort) state_nxt = FETCH;
      end
      FETCH: begin
        cfg.cfg_ready = 1'b1;
        accept        = cfg.cfg_valid;
        if (abort)              state_nxt = IDLE;
        else if (cfg.cfg_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        prog_en = 1'b1;
        prog_in = sh_buf[0];
        // Reaching the chain length wins over the word boundary, so the
        // unused top of the last word is simply dropped.
        if (abort)                         state_nxt = IDLE;
        else if (bit_count == LAST)        state_nxt = DONE;
        else if (bits_left == BL_W'(1))    state_nxt = FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      sh_buf    <= '0;
      bits_left <= '0;
      bit_count <= '0;
      fabric_en <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            bit_count <= '0;
            fabric_en <= 1'b0;
            aborted   <= 1'b0;
          end
        end
        FETCH: begin
          // A word offered while ready is consumed even on an abort edge,
          // so the host never sees a ready/valid pair that went nowhere.
          if (accept) begin
            sh_buf    <= cfg.cfg_data;
            bits_left <= BL_W'(WORD_W);
          end
          if (abort) aborted <= 1'b1;
        end
        SHIFT: begin
          sh_buf    <= sh_buf >> 1;
          bits_left <= bits_left - BL_W'(1);
          // prog_en is high this cycle even when abort arrives, so the chain
          // really moved and the bit is counted.
          if (bit_count != FULL) bit_count <= bit_count + CNT_W'(1);
          if (abort) aborted <= 1'b1;
        end
        DONE:    fabric_en <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cfg_chain_loader.sv
module tb_cfg_chain_loader;
  logic       prog_clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0;
  logic       start8 = 1'b0, abort8 = 1'b0;
  logic       prog_out = 1'b0, prog_out8 = 1'b0;
  logic       prog_in, prog_en, fabric_en, busy, done, aborted;
  logic [4:0] bit_count;
  logic       prog_in8, prog_en8, fabric_en8, busy8, done8, aborted8;
  logic [3:0] bit_count8;

  int total = 0;
  int bad   = 0;

  logic [7:0]  words [3];
  logic [31:0] stream;
  int          nbits, ndone, bubbles, noise;

  always #5 prog_clk = ~prog_clk;

  cfg_chain_loader_if #(.WORD_W(8)) h ();
  cfg_chain_loader_if #(.WORD_W(8)) h8 ();

  cfg_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut (
    .prog_clk(prog_clk), .prog_rst(rst), .start(start), .abort(abort), .cfg(h),
    .prog_in(prog_in), .prog_en(prog_en), .prog_out(prog_out), .fabric_en(fabric_en),
    .busy(busy), .done(done), .aborted(aborted), .bit_count(bit_count)
  );

  cfg_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_dut8 (
    .prog_clk(prog_clk), .prog_rst(rst), .start(start8), .abort(abort8), .cfg(h8),
    .prog_in(prog_in8), .prog_en(prog_en8), .prog_out(prog_out8), .fabric_en(fabric_en8),
    .busy(busy8), .done(done8), .aborted(aborted8), .bit_count(bit_count8)
  );

  // Runs one load on u_dut; word index follows bit_count/8. Optional events:
  // stall_cyc FETCH cycles with valid low before word 1, abort/reset/restart
  // raised on the shift cycle where bit_count equals the given value.
  task automatic run_load(input int stall_cyc, input int abort_at, input int rst_at,
                          input int restart_at);
    int s;
    int widx;
    s = 0; nbits = 0; ndone = 0; bubbles = 0; noise = 0; stream = '0;
    h.cfg_valid = 1'b0;
    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      abort = 1'b0; rst = 1'b0; start = 1'b0;
      if (!busy) break;
      if (prog_en) begin
        if (nbits < 32) stream[nbits] = prog_in;
        nbits++;
      end else if (prog_in) noise++;
      if (done) ndone++;
      if (!prog_en && !done && nbits > 0) bubbles++;
      if (h.cfg_ready) begin
        widx = int'(bit_count) / 8;
        if (widx > 2) widx = 2;
        h.cfg_data = words[widx];
        if (widx == 1 && s < stall_cyc) begin h.cfg_valid = 1'b0; s++; end
        else h.cfg_valid = 1'b1;
      end
      if (prog_en && int'(bit_count) == abort_at)   abort = 1'b1;
      if (prog_en && int'(bit_count) == rst_at)     rst   = 1'b1;
      if (prog_en && int'(bit_count) == restart_at) start = 1'b1;
      @(negedge prog_clk);
    end
    abort = 1'b0; rst = 1'b0; start = 1'b0;
    h.cfg_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL load_timeout: busy=%0b want 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; h.cfg_valid = 1'b0; h8.cfg_valid = 1'b0; h.cfg_data = '0; h8.cfg_data = '0;
    repeat (2) @(negedge prog_clk);
    total++; if ({prog_in, prog_en, fabric_en, busy, done, aborted} !== 6'b0) begin bad++; $display("FAIL reset_flags: got %b want 000000", {prog_in, prog_en, fabric_en, busy, done, aborted}); end
    total++; if (bit_count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bit_count); end
    total++; if (h.cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", h.cfg_ready); end
    total++; if ({prog_en8, fabric_en8, busy8, bit_count8} !== 7'b0) begin bad++; $display("FAIL reset_dut8: got %b want 0", {prog_en8, fabric_en8, busy8, bit_count8}); end
    rst = 1'b0;
  endtask

  task automatic test_full_load();
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    run_load(0, -1, -1, -1);
    total++; if (nbits !== 20) begin bad++; $display("FAIL full_nbits: got %0d want 20", nbits); end
    total++; if (stream[19:0] !== 20'hF3CA5) begin bad++; $display("FAIL full_stream: got %h want f3ca5", stream[19:0]); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL full_done: got %0d want 1", ndone); end
    total++; if (fabric_en !== 1'b1) begin bad++; $display("FAIL full_fabric: got %b want 1", fabric_en); end
    total++; if (bit_count !== 5'd20) begin bad++; $display("FAIL full_count: got %0d want 20", bit_count); end
    total++; if (bubbles !== 2) begin bad++; $display("FAIL full_bubbles: got %0d want 2", bubbles); end
    total++; if (noise !== 0) begin bad++; $display("FAIL full_idle_data: got %0d want 0", noise); end
    total++; if (aborted !== 1'b0) begin bad++; $display("FAIL full_aborted: got %b want 0", aborted); end
  endtask

  task automatic test_host_stall();
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    run_load(5, -1, -1, -1);
    total++; if (stream[19:0] !== 20'hF3CA5 || nbits !== 20) begin bad++; $display("FAIL stall_stream: got %h/%0d want f3ca5/20", stream[19:0], nbits); end
    // 6 FETCH cycles before word 1 (5 stalled + accept) plus 1 before word 2.
    total++; if (bubbles !== 7) begin bad++; $display("FAIL stall_bubbles: got %0d want 7", bubbles); end
    total++; if (ndone !== 1 || fabric_en !== 1'b1) begin bad++; $display("FAIL stall_done: got done=%0d fab=%b want 1/1", ndone, fabric_en); end
  endtask

  task automatic test_abort();
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    run_load(0, 10, -1, -1);
    total++; if (bit_count !== 5'd11 || nbits !== 11) begin bad++; $display("FAIL abort_count: got %0d/%0d want 11/11", bit_count, nbits); end
    total++; if (stream[10:0] !== 11'h4A5) begin bad++; $display("FAIL abort_stream: got %h want 4a5", stream[10:0]); end
    total++; if (aborted !== 1'b1 || fabric_en !== 1'b0 || prog_en !== 1'b0) begin bad++; $display("FAIL abort_flags: got ab=%b fab=%b en=%b want 1/0/0", aborted, fabric_en, prog_en); end
    total++; if (ndone !== 0) begin bad++; $display("FAIL abort_done: got %0d want 0", ndone); end
    run_load(0, -1, -1, -1);
    total++; if (aborted !== 1'b0 || ndone !== 1 || bit_count !== 5'd20) begin bad++; $display("FAIL abort_reload: got ab=%b done=%0d cnt=%0d want 0/1/20", aborted, ndone, bit_count); end
    total++; if (stream[19:0] !== 20'hF3CA5) begin bad++; $display("FAIL abort_reload_stream: got %h want f3ca5", stream[19:0]); end
  endtask

  task automatic test_reset_midload();
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    run_load(0, -1, 5, -1);
    total++; if ({prog_in, prog_en, fabric_en, busy, done, aborted, h.cfg_ready} !== 7'b0) begin bad++; $display("FAIL rst_flags: got %b want 0000000", {prog_in, prog_en, fabric_en, busy, done, aborted, h.cfg_ready}); end
    total++; if (bit_count !== 5'd0 || ndone !== 0) begin bad++; $display("FAIL rst_count: got cnt=%0d done=%0d want 0/0", bit_count, ndone); end
  endtask

  task automatic test_start_ignored();
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    run_load(0, -1, -1, 12);
    total++; if (stream[19:0] !== 20'hF3CA5 || nbits !== 20 || ndone !== 1) begin bad++; $display("FAIL restart_load: got %h/%0d/%0d want f3ca5/20/1", stream[19:0], nbits, ndone); end
    @(negedge prog_clk); start = 1'b1; abort = 1'b1; h.cfg_valid = 1'b1;
    total++; if (h.cfg_ready !== 1'b0) begin bad++; $display("FAIL idle_ready: got %b want 0", h.cfg_ready); end
    @(negedge prog_clk); start = 1'b0; abort = 1'b0;
    @(negedge prog_clk); h.cfg_valid = 1'b0;
    total++; if (busy !== 1'b0 || bit_count !== 5'd20 || fabric_en !== 1'b1 || aborted !== 1'b0) begin bad++; $display("FAIL start_abort_idle: got busy=%b cnt=%0d fab=%b ab=%b want 0/20/1/0", busy, bit_count, fabric_en, aborted); end
  endtask

  task automatic test_short_chain();
    logic [7:0] s8;
    int n8, nfetch, nd, last_c, done_c;
    s8 = '0; n8 = 0; nfetch = 0; nd = 0; last_c = -10; done_c = -1;
    h8.cfg_data = 8'h96; h8.cfg_valid = 1'b1;
    @(negedge prog_clk); start8 = 1'b1;
    @(negedge prog_clk); start8 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!busy8) break;
      if (prog_en8) begin
        if (n8 < 8) s8[n8] = prog_in8;
        n8++; last_c = c;
      end
      if (h8.cfg_ready) nfetch++;
      if (done8) begin nd++; done_c = c; end
      @(negedge prog_clk);
    end
    h8.cfg_valid = 1'b0;
    total++; if (n8 !== 8 || s8 !== 8'h96) begin bad++; $display("FAIL short_stream: got %h/%0d want 96/8", s8, n8); end
    total++; if (nfetch !== 1) begin bad++; $display("FAIL short_fetch: got %0d want 1", nfetch); end
    total++; if (nd !== 1 || done_c !== last_c + 1) begin bad++; $display("FAIL short_done: got n=%0d at %0d want 1 at %0d", nd, done_c, last_c + 1); end
    total++; if (bit_count8 !== 4'd8 || fabric_en8 !== 1'b1 || busy8 !== 1'b0) begin bad++; $display("FAIL short_final: got cnt=%0d fab=%b busy=%b want 8/1/0", bit_count8, fabric_en8, busy8); end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_host_stall();
    test_abort();
    test_reset_midload();
    test_start_ignored();
    test_short_chain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
